// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  localparam int FETCH_ADDR_W   = 11;
  localparam int FETCH_DATA_W   = 32;
  localparam int FETCH_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, instr} buffer between the ROM return path and decode.
// Push and pop may coincide at any occupancy; flush empties it in one edge.
module fetch_skid_fifo #(
  parameter int W = 43
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop_ok;
  logic         w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  // When full, a same-cycle pop frees the slot the write pointer already points at.
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem[0] <= {W{1'b0}};
      r_mem[1] <= {W{1'b0}};
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : {W{1'b0}};
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency synchronous instruction ROM: owns the PC,
// tracks the read in flight, and buffers returns for a valid/ready decode link.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int DATA_W   = FETCH_DATA_W,
  parameter int RESET_PC = FETCH_RESET_PC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_pc,
  input  logic              i_halt,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_im_addr,
  input  logic [DATA_W-1:0] i_im_dout,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e               r_state;
  fetch_state_e               w_state_nxt;
  logic [ADDR_W-1:0]          r_pc;
  logic [ADDR_W-1:0]          r_tag;
  logic                       r_inflight;
  logic                       w_redirect_act;
  logic                       w_start_act;
  logic                       w_issue;
  logic                       w_pop;
  logic                       w_push;
  logic [2:0]                 w_level;
  logic [1:0]                 w_occ;
  logic [ADDR_W+DATA_W-1:0]   w_fifo_din;
  logic [ADDR_W+DATA_W-1:0]   w_fifo_dout;

  assign w_pop          = o_instr_valid && i_instr_ready;
  assign w_redirect_act = i_redirect && (r_state != IDLE);
  assign w_start_act    = i_start && !i_halt && !w_redirect_act && (r_state != FETCH);
  assign w_level        = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // A squashed return is simply never pushed.
  assign w_push         = r_inflight && !w_redirect_act;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a redirect holds the current state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_act) w_state_nxt = FETCH;
        else             w_state_nxt = IDLE;
      end
      FETCH: begin
        if (i_halt && !w_redirect_act) w_state_nxt = HALTED;
        else                           w_state_nxt = FETCH;
      end
      HALTED: begin
        if (w_start_act) w_state_nxt = FETCH;
        else             w_state_nxt = HALTED;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/issue decode from the current state.
  always_comb begin
    w_issue = 1'b0;
    o_busy  = 1'b0;
    case (r_state)
      FETCH: begin
        w_issue = !w_redirect_act && !i_halt && (w_level < 3'd2);
        o_busy  = 1'b1;
      end
      IDLE, HALTED: begin
        w_issue = 1'b0;
        o_busy  = r_inflight || (w_occ != 2'd0);
      end
      default: begin
        w_issue = 1'b0;
        o_busy  = 1'b0;
      end
    endcase
  end

  // PC, in-flight flag and the tag of the read in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC_V;
      r_tag      <= {ADDR_W{1'b0}};
      r_inflight <= 1'b0;
    end else begin
      if (w_redirect_act) begin
        r_pc <= i_redirect_pc;
      end else if (w_start_act) begin
        r_pc <= i_start_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + PC_ONE;
      end
      if (w_issue) begin
        r_tag <= r_pc;
      end
      r_inflight <= w_issue;
    end
  end

  assign o_im_addr  = r_pc;
  assign w_fifo_din = {r_tag, i_im_dout};

  fetch_skid_fifo #(
    .W (ADDR_W + DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect_act),
    .i_data  (w_fifo_din),
    .o_data  (w_fifo_dout),
    .o_valid (o_instr_valid),
    .o_count (w_occ)
  );

  assign o_instr    = w_fifo_dout[DATA_W-1:0];
  assign o_instr_pc = w_fifo_dout[ADDR_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a 1-cycle-latency ROM model (mem[i] = A000_0000 | i).
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] start_pc;
  logic        halt;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic [10:0] im_addr;
  logic [31:0] im_dout;
  logic [31:0] instr;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        ready;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_pc;

  instr_fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_start_pc    (start_pc),
    .i_halt        (halt),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_im_addr     (im_addr),
    .i_im_dout     (im_dout),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (instr_valid),
    .i_instr_ready (ready),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_dout <= 32'hA000_0000 | {21'd0, im_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_pc = 11'd0; halt = 1'b0;
    redirect = 1'b0; redirect_pc = 11'd0; ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (im_addr !== 11'h000) begin errors++; $display("FAIL reset_im_addr: got %h expected 000", im_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (instr !== 32'h0 || instr_pc !== 11'h000) begin errors++; $display("FAIL reset_instr: got %h/%h expected 0/0", instr, instr_pc); end
  endtask

  task automatic test_stream();
    start_pc = 11'h000; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_lat0: valid got %b expected 0", instr_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy: got %b expected 1", busy); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_lat1: valid got %b expected 0", instr_valid); end
    step();
    exp_pc = 11'h000;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (32'hA000_0000 | {21'd0, exp_pc})) begin
        errors++; $display("FAIL stream_word%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, instr_valid, instr_pc, instr, exp_pc);
      end
      exp_pc = exp_pc + 11'd1;
      step();
    end
  endtask

  task automatic test_stall();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || im_addr !== exp_pc + 11'd2) begin
        errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h addr=%h expected v=1 pc=%h addr=%h", i, instr_valid, instr_pc, im_addr, exp_pc, exp_pc + 11'd2);
      end
      step();
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (32'hA000_0000 | {21'd0, exp_pc})) begin
        errors++; $display("FAIL stall_resume%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, instr_valid, instr_pc, instr, exp_pc);
      end
      exp_pc = exp_pc + 11'd1;
      step();
    end
  endtask

  task automatic test_redirect();
    // First redirect: one word buffered plus one read in flight.
    ready = 1'b0; redirect = 1'b1; redirect_pc = 11'h100;
    step();
    redirect = 1'b0; ready = 1'b1;
    checks++; if (instr_valid !== 1'b0 || im_addr !== 11'h100) begin errors++; $display("FAIL redir_flush: got v=%b addr=%h expected v=0 addr=100", instr_valid, im_addr); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_squash: got v=%b pc=%h expected v=0", instr_valid, instr_pc); end
    step();
    exp_pc = 11'h100;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (32'hA000_0000 | {21'd0, exp_pc})) begin
        errors++; $display("FAIL redir_word%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, instr_valid, instr_pc, instr, exp_pc);
      end
      exp_pc = exp_pc + 11'd1;
      step();
    end
    // Second redirect: buffer full.
    ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 11'h180;
    step();
    redirect = 1'b0; ready = 1'b1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_full_flush: got v=%b expected 0", instr_valid); end
    step(); step();
    exp_pc = 11'h180;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (32'hA000_0000 | {21'd0, exp_pc})) begin
        errors++; $display("FAIL redir_full_word%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, instr_valid, instr_pc, instr, exp_pc);
      end
      exp_pc = exp_pc + 11'd1;
      step();
    end
  endtask

  task automatic test_wrap();
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b0) break;
      step();
    end
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got busy=%b v=%b expected 0/0", busy, instr_valid); end
    start_pc = 11'h7FE; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    exp_pc = 11'h7FE;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (32'hA000_0000 | {21'd0, exp_pc})) begin
        errors++; $display("FAIL wrap_word%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, instr_valid, instr_pc, instr, exp_pc);
      end
      exp_pc = exp_pc + 11'd1;
      step();
    end
  endtask

  task automatic test_halt();
    logic found;
    found = 1'b0;
    ready = 1'b0; redirect = 1'b1; redirect_pc = 11'h008;
    step();
    redirect = 1'b0; ready = 1'b1;
    exp_pc = 11'h008;
    for (int i = 0; i < 30; i++) begin
      if (instr_valid === 1'b1) begin
        checks++;
        if (instr_pc !== exp_pc) begin errors++; $display("FAIL halt_run: got pc=%h expected %h", instr_pc, exp_pc); end
        exp_pc = exp_pc + 11'd1;
      end
      if (im_addr === 11'h010) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL halt_reach: got im_addr=%h expected 010 within budget", im_addr); end
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid === 1'b1) begin
        checks++;
        if (instr_pc !== exp_pc) begin errors++; $display("FAIL halt_drain: got pc=%h expected %h", instr_pc, exp_pc); end
        exp_pc = exp_pc + 11'd1;
      end
      if (busy === 1'b0) break;
      step();
    end
    checks++; if (exp_pc !== 11'h010) begin errors++; $display("FAIL halt_last: got next pc=%h expected 010", exp_pc); end
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_idle: got busy=%b v=%b expected 0/0", busy, instr_valid); end
    step(); step();
    checks++; if (instr_valid !== 1'b0 || im_addr !== 11'h010) begin errors++; $display("FAIL halt_hold: got v=%b addr=%h expected 0/010", instr_valid, im_addr); end
    start_pc = 11'h020; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    exp_pc = 11'h020;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (32'hA000_0000 | {21'd0, exp_pc})) begin
        errors++; $display("FAIL halt_resume%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, instr_valid, instr_pc, instr, exp_pc);
      end
      exp_pc = exp_pc + 11'd1;
      step();
    end
  endtask

  task automatic test_reset_midfetch();
    ready = 1'b0;
    step(); step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_full: got v=%b expected 1", instr_valid); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (instr_valid !== 1'b0 || im_addr !== 11'h000 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid: got v=%b addr=%h busy=%b expected 0/000/0", instr_valid, im_addr, busy); end
    ready = 1'b1; redirect = 1'b1; redirect_pc = 11'h123;
    step();
    redirect = 1'b0;
    checks++; if (im_addr !== 11'h000 || instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_redirect: got addr=%h v=%b busy=%b expected 000/0/0", im_addr, instr_valid, busy); end
    step(); step();
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet: got v=%b busy=%b expected 0/0", instr_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
